sig_dump: RTL and testbench

- Synthesizable responder for the CPU's compliance-test halt/signature protocol.
- Snoops CPU data-side stores to three MMIO addresses: halt, signature begin, signature end.
- On halt, freezes the CPU and reads the signature region back out of the dual-port RAM's data port.
- Streams the region as XLEN-bit words over a valid/ready interface toward a host link. This is the hardware replacement for the simulation-only signature dump.

---
 rtl/sig_dump.sv | 184 ++++++++++++++++++
 tb/tb_sig_dump.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_dump.sv
// sig_dump: signature-dump responder for the compliance-test halt protocol.
// Captures the signature region bounds from CPU MMIO stores and waits for a halt
// store. On halt it freezes the CPU, reads the region out of the RAM data port,
// and streams each word over a valid/ready link.
module sig_dump #(
    parameter int               XLEN           = 32,
    parameter logic [XLEN-1:0]  ADDR_HALT      = XLEN'(32'h2000_0000),
    parameter logic [XLEN-1:0]  ADDR_SIG_BEGIN = ADDR_HALT + XLEN'(XLEN / 8),
    parameter logic [XLEN-1:0]  ADDR_SIG_END   = ADDR_HALT + XLEN'(2 * XLEN / 8),
    parameter int               RAM_AW         = 20,
    parameter int               READ_LATENCY   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_store,
    input  logic [XLEN-1:0]   address,
    input  logic [XLEN-1:0]   store_data,
    output logic              halted,
    output logic [RAM_AW-1:0] mem_raddr,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              dump_valid,
    output logic [XLEN-1:0]   dump_data,
    output logic              dump_last,
    input  logic              dump_ready,
    output logic              done
);

    // A RAM index counts halfwords, so one XLEN word covers STEP indices.
    localparam int STEP = XLEN / 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [RAM_AW-1:0]   r_begin_idx, w_begin_next;
    logic [RAM_AW-1:0]   r_end_idx,   w_end_next;
    logic [RAM_AW-1:0]   r_cur_idx,   w_cur_next;
    logic [RAM_AW-1:0]   r_mem_raddr, w_raddr_next;
    logic [1:0]          r_wait_cnt,  w_wait_next;
    logic                r_dump_valid, w_valid_next;
    logic [XLEN-1:0]     r_dump_data,  w_data_next;
    logic                r_dump_last,  w_last_next;
    logic                r_halted,     w_halted_next;
    logic                r_done,       w_done_next;

    logic                w_store_begin;
    logic                w_store_end;
    logic                w_halt_trig;
    logic [RAM_AW:0]     w_cur_plus;
    logic                w_is_last;
    logic                w_unused_bits;

    assign w_store_begin = mem_store && (address == ADDR_SIG_BEGIN);
    assign w_store_end   = mem_store && (address == ADDR_SIG_END);
    assign w_halt_trig   = mem_store && (address == ADDR_HALT) && (store_data[31:0] == 32'd1);

    // One extra bit keeps the last-word test correct when the region ends at the top of memory.
    assign w_cur_plus = {1'b0, r_cur_idx} + (RAM_AW + 1)'(STEP);
    assign w_is_last  = (w_cur_plus >= {1'b0, r_end_idx});

    // Only the halfword-index bits and the low data word matter; the rest is deliberately ignored.
    assign w_unused_bits = ^store_data;

    // Next-state and next-value logic for the dump sequencer.
    always_comb begin
        w_state_next  = r_state;
        w_begin_next  = r_begin_idx;
        w_end_next    = r_end_idx;
        w_cur_next    = r_cur_idx;
        w_raddr_next  = r_mem_raddr;
        w_wait_next   = r_wait_cnt;
        w_valid_next  = r_dump_valid;
        w_data_next   = r_dump_data;
        w_last_next   = r_dump_last;
        w_halted_next = r_halted;
        w_done_next   = r_done;
        case (r_state)
            S_IDLE: begin
                if (w_store_begin) begin
                    w_begin_next = store_data[RAM_AW:1];
                end
                if (w_store_end) begin
                    w_end_next = store_data[RAM_AW:1];
                end
                if (w_halt_trig) begin
                    w_halted_next = 1'b1;
                    w_cur_next    = r_begin_idx;
                    // Address is loaded now so the RAM sees it throughout the REQ cycle.
                    w_raddr_next  = r_begin_idx;
                    if (r_end_idx <= r_begin_idx) begin
                        w_state_next = S_DONE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                w_wait_next  = 2'd0;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_cnt == 2'(READ_LATENCY - 1)) begin
                    w_data_next  = mem_rdata;
                    w_valid_next = 1'b1;
                    w_last_next  = w_is_last;
                    w_state_next = S_OUT;
                end else begin
                    w_wait_next = r_wait_cnt + 2'd1;
                end
            end
            S_OUT: begin
                if (dump_ready) begin
                    w_valid_next = 1'b0;
                    w_cur_next   = w_cur_plus[RAM_AW-1:0];
                    w_raddr_next = w_cur_plus[RAM_AW-1:0];
                    if (r_dump_last) begin
                        w_state_next = S_DONE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next = S_REQ;
                    end
                end
            end
            S_DONE: begin
                w_done_next   = 1'b1;
                w_halted_next = 1'b1;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any dump in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_begin_idx  <= '0;
            r_end_idx    <= '0;
            r_cur_idx    <= '0;
            r_mem_raddr  <= '0;
            r_wait_cnt   <= '0;
            r_dump_valid <= 1'b0;
            r_dump_data  <= '0;
            r_dump_last  <= 1'b0;
            r_halted     <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_begin_idx  <= w_begin_next;
            r_end_idx    <= w_end_next;
            r_cur_idx    <= w_cur_next;
            r_mem_raddr  <= w_raddr_next;
            r_wait_cnt   <= w_wait_next;
            r_dump_valid <= w_valid_next;
            r_dump_data  <= w_data_next;
            r_dump_last  <= w_last_next;
            r_halted     <= w_halted_next;
            r_done       <= w_done_next;
        end
    end

    assign halted     = r_halted;
    assign mem_raddr  = r_mem_raddr;
    assign dump_valid = r_dump_valid;
    assign dump_data  = r_dump_data;
    assign dump_last  = r_dump_last;
    assign done       = r_done;

endmodule

// File: tb/tb_sig_dump.sv
// tb_sig_dump: directed bench for sig_dump (XLEN=32 and XLEN=64 instances).
module tb_sig_dump;

    localparam logic [31:0] A_HALT   = 32'h2000_0000;
    localparam logic [31:0] A_BEG    = 32'h2000_0004;
    localparam logic [31:0] A_END    = 32'h2000_0008;
    localparam logic [63:0] A64_HALT = 64'h2000_0000;
    localparam logic [63:0] A64_BEG  = 64'h2000_0008;
    localparam logic [63:0] A64_END  = 64'h2000_0010;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    // 32-bit instance signals
    logic        mem_store = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] store_data = '0;
    logic        halted;
    logic [19:0] mem_raddr;
    logic [31:0] mem_rdata = '0;
    logic        dump_valid;
    logic [31:0] dump_data;
    logic        dump_last;
    logic        dump_ready = 1'b0;
    logic        done;

    // 64-bit instance signals
    logic        s64_store = 1'b0;
    logic [63:0] s64_addr = '0;
    logic [63:0] s64_data = '0;
    logic        s64_halted;
    logic [19:0] s64_raddr;
    logic [63:0] s64_rdata = '0;
    logic        s64_valid;
    logic [63:0] s64_dump;
    logic        s64_last;
    logic        s64_ready = 1'b1;
    logic        s64_done;

    int n_checks = 0;
    int n_fail   = 0;

    // collect() results
    int          n_beats;
    int          n_valid;
    int          got_done;
    int          done_cyc;
    int          beat_cyc  [8];
    logic [31:0] beat_data [8];
    logic        beat_last [8];
    logic        halted_log[64];
    logic [19:0] raddr_log [64];

    sig_dump #(.XLEN(32)) u_dut (
        .clock(clock), .reset(reset), .mem_store(mem_store), .address(address),
        .store_data(store_data), .halted(halted), .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata), .dump_valid(dump_valid), .dump_data(dump_data),
        .dump_last(dump_last), .dump_ready(dump_ready), .done(done)
    );

    sig_dump #(.XLEN(64)) u_dut64 (
        .clock(clock), .reset(reset), .mem_store(s64_store), .address(s64_addr),
        .store_data(s64_data), .halted(s64_halted), .mem_raddr(s64_raddr),
        .mem_rdata(s64_rdata), .dump_valid(s64_valid), .dump_data(s64_dump),
        .dump_last(s64_last), .dump_ready(s64_ready), .done(s64_done)
    );

    always #5 clock = ~clock;

    // RAM contents as seen through the data port, indexed by halfword.
    function automatic logic [31:0] ram32(input logic [19:0] idx);
        case (idx)
            20'h00080: ram32 = 32'hAAAA_0001;
            20'h00082: ram32 = 32'hBBBB_0002;
            default:   ram32 = {12'hEEE, idx};
        endcase
    endfunction

    function automatic logic [63:0] ram64(input logic [19:0] idx);
        ram64 = {12'h640, idx, 12'h641, idx};
    endfunction

    // One-cycle read latency RAM models.
    always @(posedge clock) begin
        mem_rdata <= ram32(mem_raddr);
        s64_rdata <= ram64(s64_raddr);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic store32(input logic [31:0] a, input logic [31:0] d);
        @(posedge clock); #1;
        mem_store = 1'b1; address = a; store_data = d;
        @(posedge clock); #1;
        mem_store = 1'b0; address = '0; store_data = '0;
        $display("store32 addr=%h data=%h", a, d);
    endtask

    task automatic store64(input logic [63:0] a, input logic [63:0] d);
        @(posedge clock); #1;
        s64_store = 1'b1; s64_addr = a; s64_data = d;
        @(posedge clock); #1;
        s64_store = 1'b0; s64_addr = '0; s64_data = '0;
        $display("store64 addr=%h data=%h", a, d);
    endtask

    task automatic do_reset();
        @(negedge clock); reset = 1'b0;
        @(negedge clock); reset = 1'b1;
    endtask

    // Observes the 32-bit DUT cycle by cycle after a halt store; cycle 1 is N+1.
    // If late_cyc > 0, a SIG_END store is injected in that cycle.
    task automatic collect(input int budget, input int late_cyc);
        n_beats = 0; n_valid = 0; got_done = 0; done_cyc = 0;
        for (int c = 1; c <= budget; c++) begin
            if (got_done != 0) break;
            @(negedge clock);
            if (c < 64) begin
                halted_log[c] = halted;
                raddr_log[c]  = mem_raddr;
            end
            if (mem_store) begin
                mem_store = 1'b0; address = '0; store_data = '0;
            end
            if (c == late_cyc) begin
                mem_store = 1'b1; address = A_END; store_data = 32'h400;
            end
            if (dump_valid) n_valid++;
            if (dump_valid && dump_ready && n_beats < 8) begin
                beat_cyc[n_beats]  = c;
                beat_data[n_beats] = dump_data;
                beat_last[n_beats] = dump_last;
                $display("beat cyc=%0d data=%h last=%0d", c, dump_data, dump_last);
                n_beats++;
            end
            if (done) begin
                got_done = 1; done_cyc = c;
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : main
        int          n64;
        int          first;
        logic [63:0] d64 [2];
        logic        l64 [2];

        // Reset values
        repeat (2) @(negedge clock);
        check("rst_halted", halted, 1'b0);
        check("rst_valid", dump_valid, 1'b0);
        check("rst_last", dump_last, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_data", dump_data, 32'h0);
        check("rst_raddr", mem_raddr, 20'h0);
        reset = 1'b1;

        // Partial final word with XLEN=64: region 0x100..0x10C
        store64(A64_BEG, 64'h100);
        store64(A64_END, 64'h10C);
        store64(A64_HALT, 64'h1);
        n64 = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            if (s64_valid && s64_ready && n64 < 2) begin
                d64[n64] = s64_dump; l64[n64] = s64_last;
                $display("beat64 cyc=%0d data=%h last=%0d", c, s64_dump, s64_last);
                n64++;
            end
            if (s64_done) break;
        end
        check("p64_beats", n64, 2);
        check("p64_d0", d64[0], 64'h6400_0080_6410_0080);
        check("p64_l0", l64[0], 1'b0);
        check("p64_d1", d64[1], 64'h6400_0084_6410_0084);
        check("p64_l1", l64[1], 1'b1);
        check("p64_done", s64_done, 1'b1);

        // Halt store with data 2 is ignored
        store32(A_HALT, 32'h2);
        repeat (3) @(negedge clock);
        check("bad_halt_halted", halted, 1'b0);
        check("bad_halt_done", done, 1'b0);
        check("bad_halt_valid", dump_valid, 1'b0);

        // Basic dump, with a late SIG_END store during the dump
        dump_ready = 1'b1;
        store32(A_BEG, 32'h100);
        store32(A_END, 32'h108);
        store32(A_HALT, 32'h1);
        collect(30, 2);
        check("basic_halted_n1", halted_log[1], 1'b1);
        check("basic_raddr0", raddr_log[1], 20'h80);
        check("basic_raddr1", raddr_log[4], 20'h82);
        check("basic_beats", n_beats, 2);
        check("basic_cyc0", beat_cyc[0], 3);
        check("basic_d0", beat_data[0], 32'hAAAA_0001);
        check("basic_l0", beat_last[0], 1'b0);
        check("basic_cyc1", beat_cyc[1], 6);
        check("basic_d1", beat_data[1], 32'hBBBB_0002);
        check("basic_l1", beat_last[1], 1'b1);
        check("basic_done", got_done, 1);
        repeat (3) @(negedge clock);
        check("basic_done_sticky", done, 1'b1);
        check("basic_halted_sticky", halted, 1'b1);

        // Backpressure: ready low for 5 cycles after first valid
        do_reset();
        dump_ready = 1'b0;
        store32(A_BEG, 32'h100);
        store32(A_END, 32'h108);
        store32(A_HALT, 32'h1);
        first = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (dump_valid) begin first = c; break; end
        end
        check("bp_first_cyc", first, 3);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            check("bp_valid", dump_valid, 1'b1);
            check("bp_data", dump_data, 32'hAAAA_0001);
            check("bp_raddr", mem_raddr, 20'h80);
        end
        dump_ready = 1'b1;
        collect(20, 0);
        check("bp_raddr_next", raddr_log[1], 20'h82);
        check("bp_beats", n_beats, 1);
        check("bp_d1", beat_data[0], 32'hBBBB_0002);
        check("bp_l1", beat_last[0], 1'b1);
        check("bp_done", got_done, 1);

        // Reset in the middle of a dump
        do_reset();
        dump_ready = 1'b0;
        store32(A_BEG, 32'h100);
        store32(A_END, 32'h108);
        store32(A_HALT, 32'h1);
        first = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (dump_valid) begin first = c; break; end
        end
        check("mid_reached_out", first, 3);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", dump_valid, 1'b0);
        check("mid_rst_halted", halted, 1'b0);
        @(negedge clock); reset = 1'b1;
        dump_ready = 1'b1;
        store32(A_HALT, 32'h1);
        collect(10, 0);
        check("mid_redump_valid", n_valid, 0);
        check("mid_redump_done", got_done, 1);
        check("mid_redump_done_cyc", done_cyc, 1);

        // Empty region
        do_reset();
        store32(A_BEG, 32'h200);
        store32(A_END, 32'h200);
        store32(A_HALT, 32'h1);
        collect(10, 0);
        check("empty_valid", n_valid, 0);
        check("empty_done", got_done, 1);
        check("empty_halted", halted, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
